// File: rtl/ste_hslot_arb_if.sv
// ste_hslot_arb_if: requester/memory side bundle of the horizontal-blank slot
// arbiter. The master side is the requester/memory complex; the slave side
// is the arbiter itself. stat_* carry zero unless ARB_STATS_EN is defined.
interface ste_hslot_arb_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       urgent;
  logic [NREQ-1:0][22:0] req_addr;    // slice i == bits [23*i+22:23*i]
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       ack;
  logic                  read;
  logic [22:0]           saddr;
  logic [NREQ-1:0][7:0]  stat_grants;
  logic [7:0]            stat_starve;

  modport master (
    output req, urgent, req_addr,
    input  grant, ack, read, saddr, stat_grants, stat_starve
  );

  modport slave (
    input  req, urgent, req_addr,
    output grant, ack, read, saddr, stat_grants, stat_starve
  );
endinterface

// File: rtl/ste_hslot_arb.sv
// ste_hslot_arb: shares the hsync bus_cycle-0 memory slot among NREQ engines.
// A winner is picked at the end of bus_cycle 3 (urgent first, then
// round-robin among requesters still under their per-line quota), read and
// saddr are driven through bus_cycle 0, and ack pulses on the completion clk.
// Optional: define ARB_STATS_EN to build the saturating grant/starve counters.

// Per-requester state: line quota counter, eligibility, optional grant stat.
module ste_hslot_arb_lane #(
  parameter int LINE_QUOTA = 4,
  parameter int QW         = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_i,
  input  logic       urgent_i,
  input  logic       qclr_i,
  input  logic       inc_i,
  output logic       elig_o,
  output logic [7:0] stat_o
);
  logic [QW-1:0] quota_q, quota_d;
  logic          under_q;

  assign under_q = (quota_q < QW'(LINE_QUOTA));
  assign elig_o  = req_i && (urgent_i || under_q);

  // Quota next state: a new line clears, which beats a same-clk grant.
  always_comb begin
    quota_d = quota_q;
    if (qclr_i)
      quota_d = '0;
    else if (inc_i && under_q)
      quota_d = quota_q + 1'b1;
  end

  // Quota register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) quota_q <= '0;
    else          quota_q <= quota_d;
  end

`ifdef ARB_STATS_EN
  logic [7:0] stat_q;

  // Saturating count of acks delivered to this requester.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stat_q <= '0;
    else if (inc_i && (stat_q != 8'hFF))
      stat_q <= stat_q + 8'd1;
  end

  assign stat_o = stat_q;
`else
  assign stat_o = '0;
`endif
endmodule

module ste_hslot_arb #(
  parameter int NREQ       = 2,
  parameter int LINE_QUOTA = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clk_8_en,
  input  logic [1:0]        bus_cycle,
  input  logic              hsync,
  ste_hslot_arb_if.slave    bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int QW = $clog2(LINE_QUOTA + 1);

  typedef enum logic {S_IDLE = 1'b0, S_ARMED = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   win_q, win_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [22:0]     saddr_q, saddr_d;
  logic            hsync_q;

  logic            dec_pt, cmp_pt, qclr;
  logic            win_found;
  logic [IW-1:0]   win_sel;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] ack_vec;

  // (base + k) mod NREQ without a divider; base < NREQ and k < NREQ.
  function automatic logic [IW-1:0] rot_idx(input logic [IW-1:0] base, input int k);
    int j;
    j = int'(base) + k;
    if (j >= NREQ) j = j - NREQ;
    return IW'(j);
  endfunction

  assign dec_pt = clk_8_en && (bus_cycle == 2'd3);
  assign cmp_pt = clk_8_en && (bus_cycle == 2'd0);
  assign qclr   = hsync && !hsync_q;

  genvar g;
  generate
    for (g = 0; g < NREQ; g++) begin : g_lane
      ste_hslot_arb_lane #(
        .LINE_QUOTA (LINE_QUOTA),
        .QW         (QW)
      ) u_lane (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_i    (bus.req[g]),
        .urgent_i (bus.urgent[g]),
        .qclr_i   (qclr),
        .inc_i    (ack_vec[g]),
        .elig_o   (elig[g]),
        .stat_o   (bus.stat_grants[g])
      );
    end
  endgenerate

  // Winner pick: lowest-index eligible urgent, else first eligible from rr_q.
  // Loops run downward so the last hit is the preferred one.
  always_comb begin
    win_found = 1'b0;
    win_sel   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig[i] && bus.urgent[i]) begin
        win_found = 1'b1;
        win_sel   = IW'(i);
      end
    end
    if (!win_found) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (elig[rot_idx(rr_q, k)]) begin
          win_found = 1'b1;
          win_sel   = rot_idx(rr_q, k);
        end
      end
    end
  end

  // Slot FSM next state: arm at decision point, ack or abort at completion.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    win_d   = win_q;
    rr_d    = rr_q;
    saddr_d = saddr_q;
    ack_vec = '0;
    case (state_q)
      S_IDLE: begin
        if (dec_pt && hsync && win_found) begin
          state_d = S_ARMED;
          grant_d = NREQ'(1) << win_sel;
          win_d   = win_sel;
          saddr_d = bus.req_addr[win_sel];
        end
      end
      S_ARMED: begin
        if (cmp_pt) begin
          state_d = S_IDLE;
          grant_d = '0;
          // Abort (blank ended or requester withdrew) leaves rr/quota alone.
          if (hsync && bus.req[win_q]) begin
            ack_vec = grant_q;
            rr_d    = rot_idx(win_q, 1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Slot FSM and pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      win_q   <= '0;
      rr_q    <= '0;
      saddr_q <= '0;
      hsync_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      win_q   <= win_d;
      rr_q    <= rr_d;
      saddr_q <= saddr_d;
      hsync_q <= hsync;
    end
  end

  assign bus.grant = grant_q;
  assign bus.ack   = ack_vec;
  assign bus.saddr = saddr_q;
  // read tracks hsync directly so a blank ending mid-slot drops it at once.
  assign bus.read  = (state_q == S_ARMED) && (bus_cycle == 2'd0) && hsync;

`ifdef ARB_STATS_EN
  logic       starve;
  logic [7:0] starve_q;

  assign starve = dec_pt && hsync && (state_q == S_IDLE) && (|bus.req) && !win_found;

  // Saturating count of decision points lost with requests pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      starve_q <= '0;
    else if (starve && (starve_q != 8'hFF))
      starve_q <= starve_q + 8'd1;
  end

  assign bus.stat_starve = starve_q;
`else
  assign bus.stat_starve = '0;
`endif

  a_grant_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(grant_q));
  a_ack_onehot:   assert property (@(posedge clk) disable iff (!reset_n) $onehot0(ack_vec));
  a_read_armed:   assert property (@(posedge clk) disable iff (!reset_n) bus.read |-> (state_q == S_ARMED));
endmodule

// File: tb/tb_ste_hslot_arb.sv
// tb_ste_hslot_arb: directed scenarios plus random traffic against a
// behavioural slot model; stats checks follow the ARB_STATS_EN build option.
`timescale 1ns/1ps
module tb_ste_hslot_arb;
  localparam int NREQ = 2;
  localparam int LQ   = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clk_8_en;
  logic [1:0] bus_cycle;
  logic       hsync;

  int bc, sub;
  int checks = 0;
  int errors = 0;

  ste_hslot_arb_if #(.NREQ(NREQ)) bus();

  ste_hslot_arb #(.NREQ(NREQ), .LINE_QUOTA(LQ)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clk_8_en  (clk_8_en),
    .bus_cycle (bus_cycle),
    .hsync     (hsync),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // model state
  bit          m_armed;
  int          m_win, m_rr, m_starve;
  logic [22:0] m_saddr;
  int          m_quota[NREQ];
  int          m_sg[NREQ];
  bit          m_hs_d;
  int          m_log[$];
  int          d_log[$];
  int          exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare a log tail (model or DUT ack indices) with exp_q.
  task automatic chk_seq(input string name, input int base, input bit use_dut);
    int n;
    n = use_dut ? d_log.size() : m_log.size();
    chk({name, "_count"}, n - base, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      if (base + k < n)
        chk(name, use_dut ? d_log[base + k] : m_log[base + k], exp_q[k]);
  endtask

  // One 32 MHz clock; clk_8_en marks the last clk of each bus_cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    sub = sub + 1;
    if (sub == 4) begin
      sub = 0;
      bc  = (bc + 1) % 4;
    end
    bus_cycle = 2'(bc);
    clk_8_en  = (sub == 3);
    #1;
  endtask

  task automatic go_to(input int b, input int s);
    int n;
    n = 0;
    while (!(bc == b && sub == s) && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) begin
      checks++;
      errors++;
      $display("FAIL go_to: phase %0d/%0d not reached", b, s);
    end
  endtask

  task automatic slots(input int n);
    repeat (16 * n) tick();
  endtask

  // Per-clk compare against the model, then advance the model to the edge.
  always @(negedge clk) begin
    logic [NREQ-1:0] e_grant, e_ack;
    logic            e_read;
    bit              dp, cp;
    int              w, ai;
    if (!reset_n) begin
      m_armed = 0; m_win = 0; m_rr = 0; m_saddr = '0; m_hs_d = 0; m_starve = 0;
      for (int i = 0; i < NREQ; i++) begin m_quota[i] = 0; m_sg[i] = 0; end
      chk("rst_grant", bus.grant, 0);
      chk("rst_ack",   bus.ack,   0);
      chk("rst_read",  bus.read,  0);
      chk("rst_saddr", bus.saddr, 0);
    end else begin
      dp = clk_8_en && (bus_cycle == 2'd3);
      cp = clk_8_en && (bus_cycle == 2'd0);
      e_grant = '0;
      e_ack   = '0;
      if (m_armed) e_grant[m_win] = 1'b1;
      if (m_armed && cp && hsync && bus.req[m_win]) e_ack[m_win] = 1'b1;
      e_read = m_armed && (bus_cycle == 2'd0) && hsync;
      chk("grant", bus.grant, e_grant);
      chk("ack",   bus.ack,   e_ack);
      chk("read",  bus.read,  e_read);
      chk("saddr", bus.saddr, m_saddr);
`ifdef ARB_STATS_EN
      for (int i = 0; i < NREQ; i++) chk("stat_grants", bus.stat_grants[i], m_sg[i]);
      chk("stat_starve", bus.stat_starve, m_starve);
`else
      for (int i = 0; i < NREQ; i++) chk("stat_grants", bus.stat_grants[i], 0);
      chk("stat_starve", bus.stat_starve, 0);
`endif
      ai = -1;
      for (int i = NREQ - 1; i >= 0; i--) if (bus.ack[i]) ai = i;
      if (ai >= 0) d_log.push_back(ai);

      ai = -1;
      if (m_armed) begin
        if (cp) begin
          if (e_ack != '0) begin
            ai = m_win;
            m_log.push_back(m_win);
            m_rr = (m_win + 1) % NREQ;
            if (m_sg[m_win] < 255) m_sg[m_win]++;
          end
          m_armed = 0;
        end
      end else if (dp && hsync) begin
        w = -1;
        for (int i = NREQ - 1; i >= 0; i--)
          if (bus.req[i] && bus.urgent[i]) w = i;
        if (w < 0)
          for (int k = NREQ - 1; k >= 0; k--)
            if (bus.req[(m_rr + k) % NREQ] && m_quota[(m_rr + k) % NREQ] < LQ) w = (m_rr + k) % NREQ;
        if (w >= 0) begin
          m_armed = 1;
          m_win   = w;
          m_saddr = bus.req_addr[w];
        end else if (bus.req != '0 && m_starve < 255) begin
          m_starve++;
        end
      end
      if (hsync && !m_hs_d) begin
        for (int i = 0; i < NREQ; i++) m_quota[i] = 0;
      end else if (ai >= 0 && m_quota[ai] < LQ) begin
        m_quota[ai]++;
      end
      m_hs_d = hsync;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, d0;
    reset_n = 0; clk_8_en = 0; bus_cycle = 0; hsync = 0; bc = 0; sub = 0;
    bus.req = '0; bus.urgent = '0; bus.req_addr = '0;
    repeat (3) tick();
    chk("reset_grant", bus.grant, 0);
    chk("reset_read",  bus.read,  0);
    reset_n = 1;
    go_to(1, 0);

    // round-robin, both requesting
    n0 = m_log.size(); d0 = d_log.size();
    hsync = 1; bus.req = 2'b11;
    slots(4);
    hsync = 0; bus.req = '0;
    exp_q = {0, 1, 0, 1};
    chk_seq("rr_model", n0, 0);
    chk_seq("rr_dut", d0, 1);
    slots(1);

    // single requester
    hsync = 1; bus.req = 2'b01;
    bus.req_addr[0] = 23'h012340; bus.req_addr[1] = 23'h7ABCDE;
    go_to(3, 3);
    chk("single_pre_grant", bus.grant, 0);
    tick();
    chk("single_grant", bus.grant, 2'b01);
    chk("single_saddr", bus.saddr, 23'h012340);
    chk("single_read",  bus.read,  1);
    chk("single_noack", bus.ack,   0);
    go_to(0, 3);
    chk("single_ack", bus.ack, 2'b01);
    tick();
    bus.req = '0;
    #1;
    chk("single_ack_end",   bus.ack,   0);
    chk("single_grant_end", bus.grant, 0);
    hsync = 0;
    slots(1);

    // urgent, then quota exhaustion, then a quota-blocked slot
    n0 = m_log.size(); d0 = d_log.size();
    hsync = 1; bus.req = 2'b11; bus.urgent = 2'b10;
    slots(4);
    bus.urgent = '0;
    slots(4);
    bus.req = 2'b01;
    slots(1);
    hsync = 0; bus.req = '0;
    exp_q = {1, 1, 1, 1, 0, 0, 0, 0};
    chk_seq("quota_model", n0, 0);
    chk_seq("quota_dut", d0, 1);
    chk("starve_model", m_starve, 1);
    slots(1);

    // hsync abort: same requester wins next line
    hsync = 1; bus.req = 2'b11;
    go_to(0, 0);
    chk("abort_grant", bus.grant, 2'b10);
    tick();
    hsync = 0;
    #1;
    chk("abort_read", bus.read, 0);
    go_to(0, 3);
    chk("abort_noack", bus.ack, 0);
    tick();
    chk("abort_grant_clr", bus.grant, 0);
    slots(1);
    hsync = 1;
    go_to(0, 0);
    chk("abort_retry_grant", bus.grant, 2'b10);
    go_to(0, 3);
    chk("abort_retry_ack", bus.ack, 2'b10);
    tick();
    hsync = 0; bus.req = '0;
    slots(1);

    // reset while armed in bus_cycle 0
    hsync = 1; bus.req = 2'b11;
    go_to(0, 1);
    chk("rstmid_grant_pre", bus.grant, 2'b01);
    chk("rstmid_read_pre",  bus.read,  1);
    reset_n = 0;
    #1;
    chk("rstmid_read",  bus.read,  0);
    chk("rstmid_grant", bus.grant, 0);
    chk("rstmid_ack",   bus.ack,   0);
    tick(); tick();
    reset_n = 1;
    #1;
    chk("rstmid_idle_ack",  bus.ack,  0);
    chk("rstmid_idle_read", bus.read, 0);
    tick();
    go_to(0, 0);
    chk("rstmid_next_grant", bus.grant, 2'b01);
    go_to(0, 3);
    chk("rstmid_next_ack", bus.ack, 2'b01);
    tick();
    hsync = 0; bus.req = '0;
    slots(1);

    // 300 urgent acks to requester 0: grant stat saturates
    n0 = m_log.size();
    hsync = 1; bus.req = 2'b01; bus.urgent = 2'b01;
    slots(300);
    hsync = 0; bus.req = '0; bus.urgent = '0;
    chk("stat_ack_count", m_log.size() - n0, 300);
    chk("stat_model_sg0", m_sg[0], 255);
`ifdef ARB_STATS_EN
    chk("stat_grants0_sat", bus.stat_grants[0], 255);
`else
    chk("stat_grants0_off", bus.stat_grants[0], 0);
`endif
    slots(1);

    // random traffic; hsync only rises at bus_cycle 1, may fall anywhere
    for (int t = 0; t < 6400; t++) begin
      tick();
      if ($urandom_range(7) == 0)  bus.req    = NREQ'($urandom);
      if ($urandom_range(15) == 0) bus.urgent = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) bus.req_addr[i] = 23'($urandom);
      if (bc == 1 && sub == 0 && $urandom_range(3) == 0) hsync = !hsync;
      else if (hsync && $urandom_range(63) == 0)         hsync = 0;
    end
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
